neopixel_frame_sequencer: RTL and testbench
===========================================

// Module: neopixel_frame_sequencer
// PURPOSE
//  Avalon-MM master that sequences a NEOPIXEL engine's CSR port so the host need not babysit it:
//  loads timing/mask shadows, kicks string updates at a programmed frame period, waits for the
//  engine IRQ, counts frames, flags overrun/timeout. Sits between the host CSR bus and NEOPIXEL CSR.
// PARAMETERS
//  pTIMEOUT_DEFAULT  32'h00FF_FFFF  reset value of TIMEOUT register (clocks)
//  pPERIOD_DEFAULT   32'd0          reset value of PERIOD register (0 = back-to-back frames)
// PORTS
//  iCLOCK            in   1   single clock
//  iRESET            in   1   synchronous, active-high reset
//  iCSR_ADDRESS      in   4   host register index
//  iCSR_READ         in   1   host read strobe
//  oCSR_READ_DATA    out  32  registered read data, valid 1 cycle after iCSR_READ
//  iCSR_WRITE        in   1   host write strobe
//  iCSR_WRITE_DATA   in   32  host write data
//  oNP_ADDRESS       out  4   NEOPIXEL CSR address
//  oNP_WRITE         out  1   NEOPIXEL CSR write strobe (no waitrequest; accepted every cycle)
//  oNP_WRITE_DATA    out  32  NEOPIXEL CSR write data
//  iNP_IRQ           in   1   NEOPIXEL end-of-string IRQ (level; cleared by its reg 1 write)
//  oIRQ              out  1   host interrupt, level
// BEHAVIOUR
//  Host regs: 0 CTRL{[3]RELOAD w1,[2]IRQ_EN,[1]ONESHOT w1 self-clr,[0]ENABLE}; 1 STATUS{[31:16]FRAMES,
//   [11:8]STATE,[3]TIMEOUT,[2]OVERRUN,[1]DONE,[0]BUSY} bits[3:1] W1C; 2 PERIOD; 3 MASK;
//   4 LEN_BITS{[14:5]STRING_LEN,[4:0]BIT_COUNT}; 5 TRESET; 6 T0H; 7 T1H; 8 TT (16b); 9 TIMEOUT.
//  Reset: all outputs 0, regs 0 except PERIOD/TIMEOUT defaults, DIRTY=1, state IDLE, FRAMES=0.
//  Writes to regs 3,5..8 or CTRL.RELOAD set DIRTY. Unmapped reads return 0.
//  FSM: IDLE -> (ENABLE|ONESHOT) -> CFG if DIRTY else ARM.
//   CFG: snapshot regs 3..8, clear DIRTY, then 5 consecutive writes, one per cycle: NP2<=TRESET,
//    NP3<=T0H, NP4<=T1H, NP5<=TT, NP0<=MASK; -> ARM. Host writes during CFG re-set DIRTY, apply next frame.
//   ARM: one write NP1<={16'b0,1'b1,STRING_LEN,BIT_COUNT}; load period cnt=PERIOD, timeout cnt=TIMEOUT;
//    -> WAIT_IRQ.
//   WAIT_IRQ: done = rising edge of iNP_IRQ (registered prev; stale level ignored). Period and timeout
//    cnts decrement, saturating at 0. On done: FRAMES+1 (wraps 16b), DONE=1 -> GAP.
//    Timeout cnt reaching 0 first: TIMEOUT=1, ENABLE cleared -> IDLE (engine not touched).
//   GAP: wait period cnt==0. Then ENABLE -> CFG/ARM per DIRTY; else -> IDLE. If period already 0 on
//    entry to GAP with PERIOD!=0, OVERRUN=1 (frame longer than period); leave GAP same cycle.
//  ONESHOT runs exactly one frame then IDLE; ONESHOT while busy ignored. Clearing ENABLE mid-frame
//   completes current frame (no abort), then IDLE. BUSY=1 in all states but IDLE.
//  oIRQ = IRQ_EN & (DONE|TIMEOUT), combinational from registered flags; W1C drops it next cycle.
//   Set and W1C of same flag in one cycle: set wins.
//  Reset mid-frame: FSM IDLE next cycle, oNP_WRITE=0; engine finishes on its own, its late IRQ edge
//   is ignored in IDLE.
// STRUCTURE
//  Package neopixel_pkg: NP register index localparams (NP_MASK=0,NP_CTRL=1,NP_TRESET=2,NP_T0H=3,
//   NP_T1H=4,NP_TT=5), host register indices, state enum eSEQ_STATE {IDLE,CFG,ARM,WAIT_IRQ,GAP}.
//  No sub-module; single always block plus host CSR decode.
// TESTING (bench: NEOPIXEL model or real NEOPIXEL with behavioural memory)
//  Reset, ENABLE=0 -> oNP_WRITE never asserts, STATUS reads 0, oIRQ=0.
//  MASK=3,TT=60,T0H=20,T1H=40,TRESET=3000,LEN_BITS={9,23}, ONESHOT -> writes NP2,3,4,5,0,1 on 6
//   consecutive cycles, NP1 data 32'h0000_8137; after IRQ edge FRAMES=1, DONE=1, back to IDLE.
//  Second ONESHOT with no reg changes -> only NP1 write (CFG skipped); write T0H mid-WAIT -> next frame
//   performs full CFG with new T0H.
//  ENABLE, PERIOD=100000, IRQ_EN=1 -> successive NP1 writes exactly 100000 cycles apart, oIRQ each
//   frame until DONE W1C; OVERRUN stays 0.
//  PERIOD=10 with frame ~2000 cycles -> OVERRUN=1, NP1 rewrite 1-2 cycles after each IRQ edge.
//  TIMEOUT=50, model never raises IRQ -> after 50 cycles TIMEOUT=1, ENABLE=0, IDLE; iRESET mid-WAIT
//   -> IDLE next cycle, FRAMES=0, later IRQ edge ignored.

Source files
------------

// File: rtl/neopixel_pkg.sv
// Shared definitions for the NEOPIXEL frame sequencer:
// engine/host register indices, FSM state enum, counter helper.
package neopixel_pkg;

  localparam logic [3:0] NP_MASK   = 4'd0;
  localparam logic [3:0] NP_CTRL   = 4'd1;
  localparam logic [3:0] NP_TRESET = 4'd2;
  localparam logic [3:0] NP_T0H    = 4'd3;
  localparam logic [3:0] NP_T1H    = 4'd4;
  localparam logic [3:0] NP_TT     = 4'd5;

  localparam logic [3:0] H_CTRL    = 4'd0;
  localparam logic [3:0] H_STATUS  = 4'd1;
  localparam logic [3:0] H_PERIOD  = 4'd2;
  localparam logic [3:0] H_MASK    = 4'd3;
  localparam logic [3:0] H_LEN     = 4'd4;
  localparam logic [3:0] H_TRESET  = 4'd5;
  localparam logic [3:0] H_T0H     = 4'd6;
  localparam logic [3:0] H_T1H     = 4'd7;
  localparam logic [3:0] H_TT      = 4'd8;
  localparam logic [3:0] H_TIMEOUT = 4'd9;

  typedef enum logic [2:0] {
    IDLE, CFG, ARM, WAIT_IRQ, GAP
  } eSEQ_STATE;

  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

endpackage

// File: rtl/neopixel_frame_sequencer.sv
// Avalon-MM master that configures and kicks a NEOPIXEL engine
// each frame period. Host CSR in (iCSR_*), engine CSR out (oNP_*),
// engine IRQ in (iNP_IRQ), host IRQ out (oIRQ).
module neopixel_frame_sequencer
  import neopixel_pkg::*;
#(
  parameter logic [31:0] pTIMEOUT_DEFAULT = 32'h00FF_FFFF,
  parameter logic [31:0] pPERIOD_DEFAULT  = 32'd0
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic [3:0]  iCSR_ADDRESS,
  input  logic        iCSR_READ,
  output logic [31:0] oCSR_READ_DATA,
  input  logic        iCSR_WRITE,
  input  logic [31:0] iCSR_WRITE_DATA,
  output logic [3:0]  oNP_ADDRESS,
  output logic        oNP_WRITE,
  output logic [31:0] oNP_WRITE_DATA,
  input  logic        iNP_IRQ,
  output logic        oIRQ
);

  eSEQ_STATE   state_q, state_d;
  logic        enable_q, enable_d;
  logic        irq_en_q, irq_en_d;
  logic        dirty_q, dirty_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic        tmo_q, tmo_d;
  logic [15:0] frames_q, frames_d;
  logic [31:0] period_q, period_d;
  logic [31:0] mask_q, mask_d;
  logic [14:0] len_q, len_d;
  logic [31:0] treset_q, treset_d;
  logic [31:0] t0h_q, t0h_d;
  logic [31:0] t1h_q, t1h_d;
  logic [15:0] tt_q, tt_d;
  logic [31:0] timeout_q, timeout_d;
  logic [31:0] s_mask_q, s_mask_d;
  logic [31:0] s_treset_q, s_treset_d;
  logic [31:0] s_t0h_q, s_t0h_d;
  logic [31:0] s_t1h_q, s_t1h_d;
  logic [15:0] s_tt_q, s_tt_d;
  logic [2:0]  cfg_idx_q, cfg_idx_d;
  logic [31:0] per_cnt_q, per_cnt_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        irq_prev_q, irq_prev_d;
  logic [31:0] rdata_q, rdata_d;

  logic        busy;
  logic        wr;
  logic [31:0] wd;
  logic        oneshot_wr;
  logic        host_dirty;
  logic        irq_rise;
  logic        launch;

  assign wr   = iCSR_WRITE;
  assign wd   = iCSR_WRITE_DATA;
  assign busy = (state_q != IDLE);
  assign oneshot_wr = wr && (iCSR_ADDRESS == H_CTRL) && wd[1];
  assign irq_rise   = iNP_IRQ && !irq_prev_q;
  assign host_dirty = wr && (
    (iCSR_ADDRESS == H_MASK)   ||
    (iCSR_ADDRESS == H_TRESET) ||
    (iCSR_ADDRESS == H_T0H)    ||
    (iCSR_ADDRESS == H_T1H)    ||
    (iCSR_ADDRESS == H_TT)     ||
    ((iCSR_ADDRESS == H_CTRL) && wd[3]));

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      state_q    <= IDLE;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      dirty_q    <= 1'b1;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      tmo_q      <= 1'b0;
      frames_q   <= '0;
      period_q   <= pPERIOD_DEFAULT;
      mask_q     <= '0;
      len_q      <= '0;
      treset_q   <= '0;
      t0h_q      <= '0;
      t1h_q      <= '0;
      tt_q       <= '0;
      timeout_q  <= pTIMEOUT_DEFAULT;
      s_mask_q   <= '0;
      s_treset_q <= '0;
      s_t0h_q    <= '0;
      s_t1h_q    <= '0;
      s_tt_q     <= '0;
      cfg_idx_q  <= '0;
      per_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      irq_prev_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      dirty_q    <= dirty_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      tmo_q      <= tmo_d;
      frames_q   <= frames_d;
      period_q   <= period_d;
      mask_q     <= mask_d;
      len_q      <= len_d;
      treset_q   <= treset_d;
      t0h_q      <= t0h_d;
      t1h_q      <= t1h_d;
      tt_q       <= tt_d;
      timeout_q  <= timeout_d;
      s_mask_q   <= s_mask_d;
      s_treset_q <= s_treset_d;
      s_t0h_q    <= s_t0h_d;
      s_t1h_q    <= s_t1h_d;
      s_tt_q     <= s_tt_d;
      cfg_idx_q  <= cfg_idx_d;
      per_cnt_q  <= per_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      irq_prev_q <= irq_prev_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    dirty_d    = dirty_q;
    done_d     = done_q;
    ovr_d      = ovr_q;
    tmo_d      = tmo_q;
    frames_d   = frames_q;
    period_d   = period_q;
    mask_d     = mask_q;
    len_d      = len_q;
    treset_d   = treset_q;
    t0h_d      = t0h_q;
    t1h_d      = t1h_q;
    tt_d       = tt_q;
    timeout_d  = timeout_q;
    s_mask_d   = s_mask_q;
    s_treset_d = s_treset_q;
    s_t0h_d    = s_t0h_q;
    s_t1h_d    = s_t1h_q;
    s_tt_d     = s_tt_q;
    cfg_idx_d  = cfg_idx_q;
    per_cnt_d  = per_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    irq_prev_d = iNP_IRQ;
    rdata_d    = '0;
    launch     = 1'b0;

    if (wr) begin
      case (iCSR_ADDRESS)
        H_CTRL: begin
          enable_d = wd[0];
          irq_en_d = wd[2];
        end
        H_STATUS: begin
          done_d = done_q & ~wd[1];
          ovr_d  = ovr_q & ~wd[2];
          tmo_d  = tmo_q & ~wd[3];
        end
        H_PERIOD:  period_d  = wd;
        H_MASK:    mask_d    = wd;
        H_LEN:     len_d     = wd[14:0];
        H_TRESET:  treset_d  = wd;
        H_T0H:     t0h_d     = wd;
        H_T1H:     t1h_d     = wd;
        H_TT:      tt_d      = wd[15:0];
        H_TIMEOUT: timeout_d = wd;
        default: ;
      endcase
    end

    if (iCSR_READ) begin
      case (iCSR_ADDRESS)
        H_CTRL:    rdata_d = {29'd0, irq_en_q, 1'b0, enable_q};
        H_STATUS:  rdata_d = {frames_q, 4'd0, 1'b0, state_q,
                              4'd0, tmo_q, ovr_q, done_q, busy};
        H_PERIOD:  rdata_d = period_q;
        H_MASK:    rdata_d = mask_q;
        H_LEN:     rdata_d = {17'd0, len_q};
        H_TRESET:  rdata_d = treset_q;
        H_T0H:     rdata_d = t0h_q;
        H_T1H:     rdata_d = t1h_q;
        H_TT:      rdata_d = {16'd0, tt_q};
        H_TIMEOUT: rdata_d = timeout_q;
        default:   rdata_d = '0;
      endcase
    end

    unique case (state_q)
      IDLE: launch = enable_q | oneshot_wr;
      CFG: begin
        cfg_idx_d = cfg_idx_q + 3'd1;
        if (cfg_idx_q == 3'd4) state_d = ARM;
      end
      ARM: begin
        // Two cycles (ARM + GAP decision) are part of the period.
        per_cnt_d = (period_q > 32'd2) ? period_q - 32'd2 : 32'd0;
        tmo_cnt_d = timeout_q;
        state_d   = WAIT_IRQ;
      end
      WAIT_IRQ: begin
        per_cnt_d = sat_dec(per_cnt_q);
        tmo_cnt_d = sat_dec(tmo_cnt_q);
        if (irq_rise) begin
          frames_d = frames_q + 16'd1;
          done_d   = 1'b1;
          state_d  = GAP;
          if (per_cnt_q == 32'd0 && period_q != 32'd0)
            ovr_d = 1'b1;
        end else if (tmo_cnt_q == 32'd0) begin
          tmo_d    = 1'b1;
          enable_d = 1'b0;
          state_d  = IDLE;
        end
      end
      GAP: begin
        per_cnt_d = sat_dec(per_cnt_q);
        if (per_cnt_q == 32'd0) begin
          if (enable_q) launch = 1'b1;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      if (dirty_q) begin
        state_d    = CFG;
        cfg_idx_d  = 3'd0;
        dirty_d    = 1'b0;
        s_mask_d   = mask_q;
        s_treset_d = treset_q;
        s_t0h_d    = t0h_q;
        s_t1h_d    = t1h_q;
        s_tt_d     = tt_q;
      end else begin
        state_d = ARM;
      end
    end

    // A host write landing on the snapshot cycle applies next frame.
    if (host_dirty) dirty_d = 1'b1;
  end

  always_comb begin
    oNP_WRITE      = 1'b0;
    oNP_ADDRESS    = 4'd0;
    oNP_WRITE_DATA = 32'd0;
    unique case (state_q)
      CFG: begin
        oNP_WRITE = 1'b1;
        case (cfg_idx_q)
          3'd0: begin
            oNP_ADDRESS    = NP_TRESET;
            oNP_WRITE_DATA = s_treset_q;
          end
          3'd1: begin
            oNP_ADDRESS    = NP_T0H;
            oNP_WRITE_DATA = s_t0h_q;
          end
          3'd2: begin
            oNP_ADDRESS    = NP_T1H;
            oNP_WRITE_DATA = s_t1h_q;
          end
          3'd3: begin
            oNP_ADDRESS    = NP_TT;
            oNP_WRITE_DATA = {16'd0, s_tt_q};
          end
          default: begin
            oNP_ADDRESS    = NP_MASK;
            oNP_WRITE_DATA = s_mask_q;
          end
        endcase
      end
      ARM: begin
        oNP_WRITE      = 1'b1;
        oNP_ADDRESS    = NP_CTRL;
        oNP_WRITE_DATA = {16'd0, 1'b1, len_q};
      end
      default: ;
    endcase
  end

  assign oCSR_READ_DATA = rdata_q;
  assign oIRQ = irq_en_q & (done_q | tmo_q);

endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// Directed bench for neopixel_frame_sequencer with a small
// NEOPIXEL engine model that raises IRQ a set time after a kick.
module tb_neopixel_frame_sequencer;

  logic        clk;
  logic        rst;
  logic [3:0]  csr_addr;
  logic        csr_rd;
  logic [31:0] csr_rdata;
  logic        csr_wr;
  logic [31:0] csr_wdata;
  logic [3:0]  np_addr;
  logic        np_write;
  logic [31:0] np_wdata;
  logic        np_irq;
  logic        irq;

  int vectors;
  int miscompares;

  int cyc;
  logic irq_seen;
  int log_cyc[$];
  logic [3:0] log_addr[$];
  logic [31:0] log_data[$];
  int np1_cyc[$];
  int irq_cyc[$];
  int frame_len;
  logic model_irq_en;
  int m_cnt;
  logic m_armed;

  neopixel_frame_sequencer dut (
    .iCLOCK          (clk),
    .iRESET          (rst),
    .iCSR_ADDRESS    (csr_addr),
    .iCSR_READ       (csr_rd),
    .oCSR_READ_DATA  (csr_rdata),
    .iCSR_WRITE      (csr_wr),
    .iCSR_WRITE_DATA (csr_wdata),
    .oNP_ADDRESS     (np_addr),
    .oNP_WRITE       (np_write),
    .oNP_WRITE_DATA  (np_wdata),
    .iNP_IRQ         (np_irq),
    .oIRQ            (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, want finish");
    $fatal(1, "watchdog");
  end

  // Engine model + write logger; all reads see pre-edge values.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    irq_seen <= np_irq;
    if (np_irq && !irq_seen) irq_cyc.push_back(cyc);
    if (np_write) begin
      log_cyc.push_back(cyc);
      log_addr.push_back(np_addr);
      log_data.push_back(np_wdata);
      if (np_addr == 4'd1) np1_cyc.push_back(cyc);
    end
    if (np_write && np_addr == 4'd1) begin
      np_irq  <= 1'b0;
      m_cnt   <= frame_len;
      m_armed <= 1'b1;
    end else if (m_armed && model_irq_en) begin
      if (m_cnt <= 1) begin
        np_irq  <= 1'b1;
        m_armed <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic host_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_wr = 1'b1;
    csr_addr = a;
    csr_wdata = d;
    @(negedge clk);
    csr_wr = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_rd = 1'b1;
    csr_addr = a;
    @(negedge clk);
    csr_rd = 1'b0;
    d = csr_rdata;
  endtask

  task automatic clear_log();
    @(negedge clk);
    log_cyc.delete();
    log_addr.delete();
    log_data.delete();
    np1_cyc.delete();
    irq_cyc.delete();
  endtask

  task automatic wait_idle(input int budget, input string nm);
    logic [31:0] s;
    int n;
    n = 0;
    s = 32'd1;
    while (s[0] && n < budget) begin
      host_read(4'd1, s);
      n++;
    end
    vectors++;
    if (s[0] !== 1'b0) begin
      $display("FAIL %s: busy=%b after %0d polls, want 0", nm, s[0], n);
      miscompares++;
    end
  endtask

  task automatic wait_np1(input int cnt, input int budget, input string nm);
    int k;
    k = 0;
    while (np1_cyc.size() < cnt && k < budget) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (np1_cyc.size() < cnt) begin
      $display("FAIL %s: %0d NP1 writes, want %0d", nm, np1_cyc.size(), cnt);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (np_write !== 1'b0) begin
      $display("FAIL rst_npwr: got %b want 0", np_write);
      miscompares++;
    end
    vectors++;
    if (irq !== 1'b0) begin
      $display("FAIL rst_irq: got %b want 0", irq);
      miscompares++;
    end
    host_read(4'd1, d);
    vectors++;
    if (d !== 32'h0) begin
      $display("FAIL rst_status: got %h want 00000000", d);
      miscompares++;
    end
    host_read(4'd2, d);
    vectors++;
    if (d !== 32'h0) begin
      $display("FAIL rst_period: got %h want 00000000", d);
      miscompares++;
    end
    host_read(4'd9, d);
    vectors++;
    if (d !== 32'h00FF_FFFF) begin
      $display("FAIL rst_timeout: got %h want 00ffffff", d);
      miscompares++;
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (log_cyc.size() != 0) begin
      $display("FAIL rst_quiet: %0d NP writes, want 0", log_cyc.size());
      miscompares++;
    end
  endtask

  task automatic test_oneshot_cfg();
    logic [3:0]  ea[6];
    logic [31:0] ed[6];
    logic [31:0] d;
    ea = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
    ed = '{32'd3000, 32'd20, 32'd40, 32'd60, 32'd3, 32'h0000_8137};
    frame_len = 30;
    host_write(4'd3, 32'd3);
    host_write(4'd8, 32'd60);
    host_write(4'd6, 32'd20);
    host_write(4'd7, 32'd40);
    host_write(4'd5, 32'd3000);
    host_write(4'd4, (32'd9 << 5) | 32'd23);
    clear_log();
    host_write(4'd0, 32'h2);
    wait_idle(200, "os1_idle");
    vectors++;
    if (log_cyc.size() != 6) begin
      $display("FAIL os1_count: got %0d writes want 6", log_cyc.size());
      miscompares++;
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (log_addr[i] !== ea[i] || log_data[i] !== ed[i] ||
            log_cyc[i] != log_cyc[0] + i) begin
          $display("FAIL os1_wr%0d: got a=%0d d=%h dc=%0d want a=%0d d=%h dc=%0d",
                   i, log_addr[i], log_data[i], log_cyc[i] - log_cyc[0],
                   ea[i], ed[i], i);
          miscompares++;
        end
      end
    end
    host_read(4'd1, d);
    vectors++;
    if (d !== 32'h0001_0002) begin
      $display("FAIL os1_status: got %h want 00010002", d);
      miscompares++;
    end
  endtask

  task automatic test_skip_cfg();
    logic [31:0] d;
    host_write(4'd1, 32'h2);
    clear_log();
    host_write(4'd0, 32'h2);
    wait_idle(200, "os2_idle");
    vectors++;
    if (log_cyc.size() != 1 || log_addr[0] !== 4'd1 ||
        log_data[0] !== 32'h0000_8137) begin
      $display("FAIL os2_np1only: got n=%0d want n=1 a=1 d=00008137",
               log_cyc.size());
      miscompares++;
    end
    host_read(4'd1, d);
    vectors++;
    if (d !== 32'h0002_0002) begin
      $display("FAIL os2_status: got %h want 00020002", d);
      miscompares++;
    end
    clear_log();
    host_write(4'd0, 32'h2);
    wait_np1(1, 50, "os3_kick");
    host_write(4'd6, 32'd25);
    wait_idle(200, "os3_idle");
    clear_log();
    host_write(4'd0, 32'h2);
    wait_idle(200, "os4_idle");
    vectors++;
    if (log_cyc.size() != 6) begin
      $display("FAIL os4_count: got %0d want 6", log_cyc.size());
      miscompares++;
    end else begin
      vectors++;
      if (log_addr[1] !== 4'd3 || log_data[1] !== 32'd25) begin
        $display("FAIL os4_t0h: got a=%0d d=%0d want a=3 d=25",
                 log_addr[1], log_data[1]);
        miscompares++;
      end
    end
  endtask

  task automatic test_period();
    logic [31:0] d;
    frame_len = 20;
    host_write(4'd1, 32'hE);
    host_write(4'd2, 32'd200);
    clear_log();
    host_write(4'd0, 32'h5);
    wait_np1(3, 1000, "per_kicks");
    if (np1_cyc.size() >= 3) begin
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (np1_cyc[i] - np1_cyc[i-1] != 200) begin
          $display("FAIL per_gap%0d: got %0d want 200",
                   i, np1_cyc[i] - np1_cyc[i-1]);
          miscompares++;
        end
      end
    end
    vectors++;
    if (irq !== 1'b1) begin
      $display("FAIL per_irq_set: got %b want 1", irq);
      miscompares++;
    end
    host_write(4'd1, 32'h2);
    vectors++;
    if (irq !== 1'b0) begin
      $display("FAIL per_irq_w1c: got %b want 0", irq);
      miscompares++;
    end
    repeat (30) @(negedge clk);
    vectors++;
    if (irq !== 1'b1) begin
      $display("FAIL per_irq_again: got %b want 1", irq);
      miscompares++;
    end
    host_read(4'd1, d);
    vectors++;
    if (d[2] !== 1'b0) begin
      $display("FAIL per_overrun: got %b want 0", d[2]);
      miscompares++;
    end
    host_write(4'd0, 32'h0);
    wait_idle(400, "per_stop");
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    frame_len = 40;
    host_write(4'd1, 32'hE);
    host_write(4'd2, 32'd10);
    clear_log();
    host_write(4'd0, 32'h1);
    wait_np1(3, 500, "ovr_kicks");
    if (np1_cyc.size() >= 3 && irq_cyc.size() >= 2) begin
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (np1_cyc[i] - irq_cyc[i-1] != 2) begin
          $display("FAIL ovr_lat%0d: got %0d want 2",
                   i, np1_cyc[i] - irq_cyc[i-1]);
          miscompares++;
        end
      end
    end
    host_read(4'd1, d);
    vectors++;
    if (d[2] !== 1'b1) begin
      $display("FAIL ovr_flag: got %b want 1", d[2]);
      miscompares++;
    end
    host_write(4'd0, 32'h0);
    wait_idle(400, "ovr_stop");
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    host_write(4'd1, 32'hE);
    host_write(4'd9, 32'd50);
    model_irq_en = 1'b0;
    clear_log();
    host_write(4'd0, 32'h1);
    wait_np1(1, 50, "tmo_kick");
    repeat (40) @(negedge clk);
    host_read(4'd1, d);
    vectors++;
    if (d[3] !== 1'b0 || d[0] !== 1'b1) begin
      $display("FAIL tmo_early: got tmo=%b busy=%b want 0 1", d[3], d[0]);
      miscompares++;
    end
    repeat (20) @(negedge clk);
    host_read(4'd1, d);
    vectors++;
    if (d[3] !== 1'b1 || d[0] !== 1'b0 || d[11:8] !== 4'd0) begin
      $display("FAIL tmo_flag: got %h want tmo=1 busy=0 state=0", d);
      miscompares++;
    end
    host_read(4'd0, d);
    vectors++;
    if (d !== 32'h0) begin
      $display("FAIL tmo_ctrl: got %h want 00000000", d);
      miscompares++;
    end
    model_irq_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    frame_len = 50;
    host_write(4'd9, 32'd1000);
    repeat (60) @(negedge clk);
    clear_log();
    host_write(4'd0, 32'h2);
    wait_np1(1, 50, "rmid_kick");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (np_write !== 1'b0) begin
      $display("FAIL rmid_npwr: got %b want 0", np_write);
      miscompares++;
    end
    host_read(4'd1, d);
    vectors++;
    if (d !== 32'h0) begin
      $display("FAIL rmid_status: got %h want 00000000", d);
      miscompares++;
    end
    clear_log();
    repeat (70) @(negedge clk);
    host_read(4'd1, d);
    vectors++;
    if (d !== 32'h0 || log_cyc.size() != 0 || irq !== 1'b0) begin
      $display("FAIL rmid_late_irq: got st=%h wr=%0d irq=%b want 0 0 0",
               d, log_cyc.size(), irq);
      miscompares++;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    irq_seen = 1'b0;
    np_irq = 1'b0;
    m_cnt = 0;
    m_armed = 1'b0;
    frame_len = 30;
    model_irq_en = 1'b1;
    rst = 1'b1;
    csr_addr = 4'd0;
    csr_rd = 1'b0;
    csr_wr = 1'b0;
    csr_wdata = 32'd0;
    test_reset();
    test_oneshot_cfg();
    test_skip_cfg();
    test_period();
    test_overrun();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
